ncl_stim_gen: RTL
=================

Name: ncl_stim_gen

Overview:
- Parametrised successor to the NCL gate stimulus generator.
- Runs exhaustive three-step transition sweeps (preset -> current -> next) on an N-input threshold gate under test.
- Holds each symbol for a programmable settle time, sequences the DUT reset, and emits a per-vector monitor record of the sampled gate output.
- Sits in gate testbenches between the bench controller (req/gnt) and the DUT.

Parameters:
- INPUT_PORTS, 3, DUT input count, legal range 1..8. Localparam CNT_MAX = 1 << INPUT_PORTS.
- HOLD_CYCLES, 1, clock cycles each symbol is driven, legal range >=1.
- DRST_CYCLES, 2, cycles the DUT reset is held active at sweep start, legal range >=1.
- RESET_PORT, 1, DUT reset present: 0 = none, 1 = present.
- RESET_SENS, 0, DUT reset polarity: 0 = active low, 1 = active high.
- PRESET_SET, 2'b11, enabled presets: bit0 = NULL (all 0), bit1 = DATA (all 1). The value 0 is treated as 2'b01.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- req  in  1  sweep request, four-phase with gnt
- y  in  1  DUT gate output
- stm_value  out  INPUT_PORTS  DUT input stimulus
- rsb  out  1  DUT reset
- gnt  out  1  sweep complete
- busy  out  1  high from leaving IDLE until entering DONE
- mon_valid  out  1  one-cycle strobe per vector
- mon_prev  out  1  preset of the record: 0 = NULL, 1 = DATA
- mon_curr  out  INPUT_PORTS  current symbol of the record
- mon_next  out  INPUT_PORTS  next symbol of the record
- mon_y  out  1  y sampled in the last cycle of the NEXT phase

Behaviour:
- Reset (rst low, asynchronous) puts the block in IDLE and zeroes all counters.
  - Outputs at reset: stm_value=0, gnt=0, busy=0, all mon_* = 0.
  - rsb at reset = RESET_SENS when RESET_PORT=1 (DUT held in reset), else 0.
- States: IDLE, DRST, PRESET, CURR, NEXT, DONE.
- IDLE: req sampled high -> DRST on the next edge, busy=1.
  - If RESET_PORT=0, DRST is skipped and the block goes directly to PRESET.
- DRST: drives rsb=RESET_SENS and stm_value=0 for DRST_CYCLES, then rsb=~RESET_SENS and goes to PRESET.
  - rsb then stays inactive until the next reset or the next sweep.
- Sweep loop order: p over enabled presets (NULL first), c = 0..CNT_MAX-1, n = 0..CNT_MAX-1 (n innermost).
- Phase durations: PRESET, CURR and NEXT each last exactly HOLD_CYCLES cycles, driving the preset, c and n respectively.
  - stm_value changes only at phase boundaries.
- Last cycle of NEXT:
  - mon_valid=1 for one cycle, with mon_prev/mon_curr/mon_next = p/c/n and mon_y = y sampled at that edge.
  - Next state is PRESET of the following vector; after the final vector it is DONE.
- Vector count = npresets*CNT_MAX^2.
- Cycles from first PRESET to DONE = 3*HOLD_CYCLES*vectors.
- Wrap-around: n wraps to 0 and increments c. c wrap increments p. After the last p the sweep is finished.
- DONE: stm_value=0, busy=0, gnt=1.
  - gnt stays high until req is sampled low, then gnt=0 and the next state is IDLE.
- req low mid-sweep: ignored, the sweep completes.
- req still high at DONE: no restart until the req low/high handshake completes.
- rst mid-sweep: immediate abort to reset values; no partial mon_valid.
- Illegal state encoding: return to IDLE.

Optional Feature:
- Macro NCL_STIM_NULL_SPACER_EN.
- Defined: a SPACER state, driving stm_value=0 for HOLD_CYCLES, is inserted between PRESET->CURR and CURR->NEXT. This gives NCL return-to-NULL behaviour.
  - Cycles per vector = 5*HOLD_CYCLES.
  - Monitor records are unchanged.
- Undefined: no SPACER state; 3*HOLD_CYCLES per vector.

Decomposition:
- Shared package ncl_tb_pkg holds:
  - the state encoding (one-hot, 6 bits, 7 with the spacer);
  - the preset codes PRE_NULL=0 and PRE_DATA=1;
  - the CNT_MAX function.
- One sub-module, ncl_stim_hold_cnt: a HOLD_CYCLES phase timer with load/terminal-count. It is instantiated once and shared by all phase states.

Test Plan:
- INPUT_PORTS=2, HOLD_CYCLES=1, PRESET_SET=2'b11, req pulse held until gnt:
  - 32 mon_valid strobes;
  - first record is p0/c0/n0;
  - last record is p1/c3/n3;
  - gnt rises 96 cycles after the first PRESET.
- Fed by a TH22 C-element model (PRESET_SET=2'b11):
  - record p0/c3/n1 gives mon_y=1;
  - record p0/c1/n2 gives mon_y=0;
  - record p1/c2/n0 gives mon_y=0.
- RESET_PORT=1, RESET_SENS=0, DRST_CYCLES=2:
  - rsb=0 during rst and during the 2 DRST cycles, then 1 for the rest of the sweep;
  - with RESET_SENS=1, polarities are inverted.
- HOLD_CYCLES=3, INPUT_PORTS=1, PRESET_SET=2'b01:
  - 4 vectors, each symbol stable for 3 cycles;
  - 36 cycles of stimulus in total.
- rst asserted during vector 5, then req reissued:
  - outputs return to reset values asynchronously;
  - the new sweep restarts at p0/c0/n0.
- gnt handshake: req held high after DONE -> gnt stays 1 with no restart; req dropped -> gnt=0 next cycle and IDLE.

Source files
------------

// File: rtl/ncl_tb_pkg.sv
// ncl_tb_pkg: shared definitions for the NCL gate stimulus generator.
//   - state_t : one-hot sequencer states (6 bits; 7 with NCL_STIM_NULL_SPACER_EN,
//               which adds the return-to-NULL S_SPACER state)
//   - PRE_NULL / PRE_DATA : preset codes carried in the monitor record
//   - cnt_max() : number of distinct symbols for a given gate input count
package ncl_tb_pkg;

`ifdef NCL_STIM_NULL_SPACER_EN
  localparam int STATE_W = 7;
`else
  localparam int STATE_W = 6;
`endif

  typedef enum logic [STATE_W-1:0] {
    S_IDLE   = STATE_W'(1 << 0),
    S_DRST   = STATE_W'(1 << 1),
    S_PRESET = STATE_W'(1 << 2),
    S_CURR   = STATE_W'(1 << 3),
    S_NEXT   = STATE_W'(1 << 4),
    S_DONE   = STATE_W'(1 << 5)
`ifdef NCL_STIM_NULL_SPACER_EN
    , S_SPACER = STATE_W'(1 << 6)
`endif
  } state_t;

  localparam logic PRE_NULL = 1'b0;  // preset drives all zeros
  localparam logic PRE_DATA = 1'b1;  // preset drives all ones

  function automatic int cnt_max(input int ports);
    return 1 << ports;
  endfunction

endpackage

// File: rtl/ncl_stim_hold_cnt.sv
// ncl_stim_hold_cnt: phase timer shared by every symbol-driving state.
// Loading on phase entry makes tc rise in the HOLD_CYCLES-th cycle of the phase.
//   clk  in  clock
//   rst  in  asynchronous active-low reset
//   load in  restart the timer (asserted on the edge that enters a phase)
//   tc   out terminal count: current cycle is the last cycle of the phase
module ncl_stim_hold_cnt #(
  parameter int HOLD_CYCLES = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic tc
);

  localparam int W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [W-1:0] LOAD_VAL = W'(HOLD_CYCLES - 1);

  logic [W-1:0] cnt;

  // NOTE: registers are updated with non-blocking assignments so every flop
  // samples pre-edge values, regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= LOAD_VAL;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign tc = (cnt == '0);

endmodule

// File: rtl/ncl_stim_gen.sv
// ncl_stim_gen: exhaustive preset -> current -> next transition sweep for an
// INPUT_PORTS-input NCL threshold gate.
//   clk        in  clock
//   rst        in  asynchronous active-low reset
//   req        in  sweep request (four-phase handshake with gnt)
//   y          in  gate output under test
//   stm_value  out gate input stimulus
//   rsb        out gate reset (polarity RESET_SENS, only driven if RESET_PORT)
//   gnt        out sweep complete, held until req is seen low
//   busy       out sweep in progress (DRST..NEXT)
//   mon_valid  out one-cycle strobe per vector, in the cycle after the vector's
//              last NEXT cycle; mon_y is y as sampled at the edge ending NEXT
//   mon_prev   out preset of the record (PRE_NULL / PRE_DATA)
//   mon_curr   out current symbol of the record
//   mon_next   out next symbol of the record
//   mon_y      out sampled gate output
// Optional: define NCL_STIM_NULL_SPACER_EN to insert an all-zero spacer phase
// between PRESET->CURR and CURR->NEXT (5*HOLD_CYCLES cycles per vector).
module ncl_stim_gen
  import ncl_tb_pkg::*;
#(
  parameter int       INPUT_PORTS = 3,
  parameter int       HOLD_CYCLES = 1,
  parameter int       DRST_CYCLES = 2,
  parameter bit       RESET_PORT  = 1'b1,
  parameter bit       RESET_SENS  = 1'b0,
  parameter logic [1:0] PRESET_SET = 2'b11
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req,
  input  logic                   y,
  output logic [INPUT_PORTS-1:0] stm_value,
  output logic                   rsb,
  output logic                   gnt,
  output logic                   busy,
  output logic                   mon_valid,
  output logic                   mon_prev,
  output logic [INPUT_PORTS-1:0] mon_curr,
  output logic [INPUT_PORTS-1:0] mon_next,
  output logic                   mon_y
);

  localparam int CNT_MAX = cnt_max(INPUT_PORTS);
  localparam logic [INPUT_PORTS-1:0] LAST_IDX = INPUT_PORTS'(CNT_MAX - 1);
  // An empty preset set falls back to NULL only.
  localparam logic [1:0] PSET    = (PRESET_SET == 2'b00) ? 2'b01 : PRESET_SET;
  localparam logic       FIRST_P = PSET[0] ? PRE_NULL : PRE_DATA;
  localparam logic       DATA_EN = PSET[1];
  localparam int         DW      = (DRST_CYCLES > 1) ? $clog2(DRST_CYCLES) : 1;
  localparam logic [DW-1:0] DRST_LOAD = DW'(DRST_CYCLES - 1);
  // Without a DUT reset the pin is parked low.
  localparam logic RSB_RST = RESET_PORT ? RESET_SENS : 1'b0;

  state_t                 state, state_next;
  logic                   p;
  logic [INPUT_PORTS-1:0] c, n;
  logic [DW-1:0]          drst_cnt;
  logic                   rsb_q;
  logic                   hold_load, hold_tc;
  logic                   last_n, last_c, last_p;
  logic                   sweep_start, vec_end, sweep_last;

`ifdef NCL_STIM_NULL_SPACER_EN
  logic spc_to_next;  // spacer exits to NEXT (set) or CURR (clear)
`endif

  assign last_n      = (n == LAST_IDX);
  assign last_c      = (c == LAST_IDX);
  assign last_p      = (p == PRE_DATA) || !DATA_EN;
  assign sweep_start = (state == S_IDLE) && req;
  assign vec_end     = (state == S_NEXT) && hold_tc;
  assign sweep_last  = last_n && last_c && last_p;

  ncl_stim_hold_cnt #(.HOLD_CYCLES(HOLD_CYCLES)) u_hold (
    .clk  (clk),
    .rst  (rst),
    .load (hold_load),
    .tc   (hold_tc)
  );

  // Every state change enters a new phase, so the timer restarts on any change.
  assign hold_load = (state_next != state);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_next;
  end

  always_comb begin
    // NOTE: every combinationally assigned signal gets a default first so no
    // path through the case leaves it unassigned, which would infer a latch.
    state_next = state;
    stm_value  = '0;
    case (state)
      S_IDLE: begin
        if (req) state_next = RESET_PORT ? S_DRST : S_PRESET;
      end
      S_DRST: begin
        if (drst_cnt == '0) state_next = S_PRESET;
      end
      S_PRESET: begin
        stm_value = {INPUT_PORTS{p}};
`ifdef NCL_STIM_NULL_SPACER_EN
        if (hold_tc) state_next = S_SPACER;
`else
        if (hold_tc) state_next = S_CURR;
`endif
      end
`ifdef NCL_STIM_NULL_SPACER_EN
      S_SPACER: begin
        if (hold_tc) state_next = spc_to_next ? S_NEXT : S_CURR;
      end
`endif
      S_CURR: begin
        stm_value = c;
`ifdef NCL_STIM_NULL_SPACER_EN
        if (hold_tc) state_next = S_SPACER;
`else
        if (hold_tc) state_next = S_NEXT;
`endif
      end
      S_NEXT: begin
        stm_value = n;
        if (hold_tc) state_next = sweep_last ? S_DONE : S_PRESET;
      end
      S_DONE: begin
        if (!req) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  assign busy = (state != S_IDLE) && (state != S_DONE);
  assign gnt  = (state == S_DONE);
  assign rsb  = rsb_q;

`ifdef NCL_STIM_NULL_SPACER_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                        spc_to_next <= 1'b0;
    else if (state == S_PRESET && state_next == S_SPACER) spc_to_next <= 1'b0;
    else if (state == S_CURR && state_next == S_SPACER)   spc_to_next <= 1'b1;
  end
`endif

  // Sweep indices: n innermost, then c, then preset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      p <= PRE_NULL;
      c <= '0;
      n <= '0;
    end else if (sweep_start) begin
      p <= FIRST_P;
      c <= '0;
      n <= '0;
    end else if (vec_end) begin
      if (!last_n) begin
        n <= n + 1'b1;
      end else begin
        n <= '0;
        if (!last_c) begin
          c <= c + 1'b1;
        end else begin
          c <= '0;
          if (!last_p) p <= PRE_DATA;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      drst_cnt <= '0;
    end else if (sweep_start) begin
      drst_cnt <= DRST_LOAD;
    end else if (state == S_DRST && drst_cnt != '0) begin
      drst_cnt <= drst_cnt - 1'b1;
    end
  end

  // DUT reset: active from reset until the end of DRST, then inactive until
  // the next reset or the next sweep.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rsb_q <= RSB_RST;
    end else if (sweep_start && RESET_PORT) begin
      rsb_q <= RESET_SENS;
    end else if (state == S_DRST && state_next == S_PRESET) begin
      rsb_q <= ~RESET_SENS;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mon_valid <= 1'b0;
      mon_prev  <= 1'b0;
      mon_curr  <= '0;
      mon_next  <= '0;
      mon_y     <= 1'b0;
    end else begin
      mon_valid <= vec_end;
      if (vec_end) begin
        mon_prev <= p;
        mon_curr <= c;
        mon_next <= n;
        mon_y    <= y;
      end
    end
  end

endmodule
